// File: rtl/uart_msg_tx.sv
// UART message transmitter: writable character buffer, configurable frame format,
// one-shot or gap-separated repeating transmission with abort.
module uart_msg_tx #(
   parameter int CLK_FREQ   = 27000000,
   parameter int BAUD_RATE  = 115200,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int MSG_DEPTH  = 32,
   parameter int GAP_CYCLES = 5000000,
   localparam int AW        = $clog2(MSG_DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 wr_en,
   input  logic [AW-1:0]        wr_addr,
   input  logic [DATA_BITS-1:0] wr_data,
   input  logic [AW:0]          msg_len,
   input  logic                 start,
   input  logic                 repeat_en,
   input  logic                 abort,
   output logic                 uart_tx,
   output logic                 busy,
   output logic                 byte_done,
   output logic                 msg_done,
   output logic [AW:0]          char_idx
);

   localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
   localparam int BCW      = $clog2(BAUD_DIV);
   localparam int GCW      = $clog2(GAP_CYCLES + 1);
   localparam int DCW      = $clog2(DATA_BITS);

   localparam logic [BCW-1:0] BAUD_LAST = BCW'(BAUD_DIV - 1);
   localparam logic [DCW-1:0] DATA_LAST = DCW'(DATA_BITS - 1);
   localparam logic [AW:0]    DEPTH     = (AW + 1)'(MSG_DEPTH);
   // Line outputs lag the state by one clock, so the gap state lasts one cycle less
   // than GAP_CYCLES to land the next start bit GAP_CYCLES after msg_done.
   localparam logic [GCW-1:0] GAP_LAST  = GCW'((GAP_CYCLES >= 2) ? GAP_CYCLES - 2 : 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PAR,
      S_STOP,
      S_GAP
   } state_t;

   logic [DATA_BITS-1:0] mem_q [MSG_DEPTH];

   state_t               state_q;
   logic [BCW-1:0]       baud_q;
   logic [DCW-1:0]       bit_q;
   logic                 stop_q;
   logic [GCW-1:0]       gap_q;
   logic [AW:0]          idx_q;
   logic [AW:0]          len_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 par_q;
   logic                 tx_q;
   logic                 busy_q;
   logic                 byte_done_q;
   logic                 msg_done_q;
   logic [AW:0]          char_idx_q;

   logic [AW:0]          len_d;
   logic                 tx_d;
   logic                 bit_end;
   logic                 last_char;
   logic [DATA_BITS-1:0] next_chr;

   function automatic logic par_of(input logic [DATA_BITS-1:0] d);
      return (^d) ^ (PARITY == 1);
   endfunction

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   always_comb begin
      len_d     = (msg_len > DEPTH) ? DEPTH : msg_len;
      bit_end   = (baud_q == BAUD_LAST);
      last_char = (idx_q == len_q - 1'b1);
      next_chr  = mem_q[idx_q[AW-1:0] + 1'b1];
      case (state_q)
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = shift_q[0];
         S_PAR:   tx_d = par_q;
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         baud_q      <= '0;
         bit_q       <= '0;
         stop_q      <= 1'b0;
         gap_q       <= '0;
         idx_q       <= '0;
         len_q       <= '0;
         shift_q     <= '0;
         par_q       <= 1'b0;
         tx_q        <= 1'b1;
         busy_q      <= 1'b0;
         byte_done_q <= 1'b0;
         msg_done_q  <= 1'b0;
         char_idx_q  <= '0;
      end else if (abort && state_q != S_IDLE) begin
         state_q     <= S_IDLE;
         baud_q      <= '0;
         idx_q       <= '0;
         tx_q        <= 1'b1;
         busy_q      <= 1'b0;
         byte_done_q <= 1'b0;
         msg_done_q  <= 1'b0;
         char_idx_q  <= '0;
      end else begin
         tx_q        <= tx_d;
         busy_q      <= (state_q != S_IDLE);
         char_idx_q  <= idx_q;
         byte_done_q <= 1'b0;
         msg_done_q  <= 1'b0;
         baud_q      <= bit_end ? '0 : baud_q + 1'b1;
         case (state_q)
            S_IDLE: begin
               baud_q <= '0;
               if (start && !abort && msg_len != '0) begin
                  state_q <= S_START;
                  idx_q   <= '0;
                  len_q   <= len_d;
                  shift_q <= mem_q[0];
                  par_q   <= par_of(mem_q[0]);
               end
            end
            S_START: begin
               if (bit_end) begin
                  state_q <= S_DATA;
                  bit_q   <= '0;
               end
            end
            S_DATA: begin
               if (bit_end) begin
                  shift_q <= shift_q >> 1;
                  bit_q   <= bit_q + 1'b1;
                  if (bit_q == DATA_LAST) begin
                     state_q <= (PARITY != 0) ? S_PAR : S_STOP;
                     stop_q  <= 1'b0;
                  end
               end
            end
            S_PAR: begin
               if (bit_end) begin
                  state_q <= S_STOP;
                  stop_q  <= 1'b0;
               end
            end
            S_STOP: begin
               if (bit_end) begin
                  if (stop_q == 1'(STOP_BITS - 1)) begin
                     byte_done_q <= 1'b1;
                     if (!last_char) begin
                        state_q <= S_START;
                        idx_q   <= idx_q + 1'b1;
                        shift_q <= next_chr;
                        par_q   <= par_of(next_chr);
                     end else begin
                        msg_done_q <= 1'b1;
                        idx_q      <= '0;
                        if (!repeat_en) begin
                           state_q <= S_IDLE;
                        end else if (GAP_CYCLES > 1) begin
                           state_q <= S_GAP;
                           gap_q   <= '0;
                        end else if (msg_len != '0) begin
                           state_q <= S_START;
                           len_q   <= len_d;
                           shift_q <= mem_q[0];
                           par_q   <= par_of(mem_q[0]);
                        end else begin
                           state_q <= S_IDLE;
                        end
                     end
                  end else begin
                     stop_q <= 1'b1;
                  end
               end
            end
            S_GAP: begin
               baud_q <= '0;
               gap_q  <= gap_q + 1'b1;
               if (gap_q == GAP_LAST) begin
                  if (msg_len != '0) begin
                     state_q <= S_START;
                     len_q   <= len_d;
                     shift_q <= mem_q[0];
                     par_q   <= par_of(mem_q[0]);
                  end else begin
                     state_q <= S_IDLE;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign uart_tx   = tx_q;
   assign busy      = busy_q;
   assign byte_done = byte_done_q;
   assign msg_done  = msg_done_q;
   assign char_idx  = char_idx_q;

endmodule
